// File: rtl/ag_mem_read.sv
// Memory-read stage behind the address-generation latch: issues word-aligned cache
// reads (two when the access straddles a word boundary) and right-justifies the operand.
module ag_mem_read #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_v,
  input  logic             i_rd,
  input  logic [31:0]      i_addr1,
  input  logic [1:0]       i_opSize,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_inv,
  input  logic             i_ack,
  input  logic [31:0]      i_cdata,
  input  logic             i_ds_stall,
  output logic             o_stall,
  output logic             o_req_v,
  output logic [31:0]      o_req_addr,
  output logic             o_v,
  output logic [31:0]      o_data,
  output logic [TAG_W-1:0] o_tag,
  output logic [CNT_W-1:0] o_split_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ1 = 2'd1,
    S_REQ2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               cross_q, cross_d;
  logic [TAG_W-1:0]   tag_in_q, tag_in_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_q, hi_d;
  logic               req_v_q, req_v_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               v_q, v_d;
  logic [31:0]        data_q, data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Size code 11 behaves as a 4-byte access; single bytes can never straddle a word.
  function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   crosses = 1'b0;
      2'b01:   crosses = (off == 2'd3);
      default: crosses = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [31:0] assemble(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off, input logic [1:0] size);
    logic [63:0] shifted;
    shifted = {hi, lo} >> {off, 3'b000};
    case (size)
      2'b00:   assemble = shifted[31:0] & 32'h0000_00FF;
      2'b01:   assemble = shifted[31:0] & 32'h0000_FFFF;
      default: assemble = shifted[31:0];
    endcase
  endfunction

  // Next-state and next-output computation; flush overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    cross_d    = cross_q;
    tag_in_d   = tag_in_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    req_v_d    = req_v_q;
    req_addr_d = req_addr_q;
    v_d        = v_q;
    data_d     = data_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_v && !i_inv) begin
          off_d    = i_addr1[1:0];
          size_d   = i_opSize;
          cross_d  = crosses(i_opSize, i_addr1[1:0]);
          tag_in_d = i_tag;
          if (i_rd) begin
            state_d    = S_REQ1;
            req_v_d    = 1'b1;
            req_addr_d = {i_addr1[31:2], 2'b00};
          end else begin
            state_d = S_DONE;
            lo_d    = 32'h0000_0000;
            hi_d    = 32'h0000_0000;
            data_d  = 32'h0000_0000;
            tag_d   = i_tag;
            v_d     = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ1: begin
        if (i_ack) begin
          lo_d = i_cdata;
          if (cross_q) begin
            state_d    = S_REQ2;
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            state_d = S_DONE;
            req_v_d = 1'b0;
            hi_d    = 32'h0000_0000;
            data_d  = assemble(32'h0000_0000, i_cdata, off_q, size_q);
            tag_d   = tag_in_q;
            v_d     = 1'b1;
          end
        end else begin
          state_d = S_REQ1;
        end
      end
      S_REQ2: begin
        if (i_ack) begin
          state_d = S_DONE;
          req_v_d = 1'b0;
          hi_d    = i_cdata;
          data_d  = assemble(i_cdata, lo_q, off_q, size_q);
          tag_d   = tag_in_q;
          v_d     = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = S_REQ2;
        end
      end
      S_DONE: begin
        if (!i_ds_stall) begin
          state_d = S_IDLE;
          v_d     = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_v_d = 1'b0;
        v_d     = 1'b0;
      end
    endcase

    // A flush discards any in-flight ack and returns straight to IDLE.
    if (i_inv) begin
      state_d    = S_IDLE;
      off_d      = off_q;
      size_d     = size_q;
      cross_d    = cross_q;
      tag_in_d   = tag_in_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      req_v_d    = 1'b0;
      req_addr_d = req_addr_q;
      v_d        = 1'b0;
      data_d     = data_q;
      tag_d      = tag_q;
      cnt_d      = cnt_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      cross_q    <= 1'b0;
      tag_in_q   <= {TAG_W{1'b0}};
      lo_q       <= 32'h0000_0000;
      hi_q       <= 32'h0000_0000;
      req_v_q    <= 1'b0;
      req_addr_q <= 32'h0000_0000;
      v_q        <= 1'b0;
      data_q     <= 32'h0000_0000;
      tag_q      <= {TAG_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      cross_q    <= cross_d;
      tag_in_q   <= tag_in_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      req_v_q    <= req_v_d;
      req_addr_q <= req_addr_d;
      v_q        <= v_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_stall     = (state_q != S_IDLE);
  assign o_req_v     = req_v_q;
  assign o_req_addr  = req_addr_q;
  assign o_v         = v_q;
  assign o_data      = data_q;
  assign o_tag       = tag_q;
  assign o_split_cnt = cnt_q;

endmodule

// File: tb/tb_ag_mem_read.sv
// Randomized bench for ag_mem_read: the bench plays the data cache from a byte-level
// memory model and predicts each operand from the bytes the access covers.
module tb_ag_mem_read;
  localparam int TAG_W = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_v, i_rd, i_inv, i_ack, i_ds_stall;
  logic [31:0]      i_addr1, i_cdata;
  logic [1:0]       i_opSize;
  logic [TAG_W-1:0] i_tag;
  logic             o_stall, o_req_v, o_v;
  logic [31:0]      o_req_addr, o_data;
  logic [TAG_W-1:0] o_tag;
  logic [CNT_W-1:0] o_split_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_m    = 0;
  logic [31:0] mem [logic [31:0]];

  ag_mem_read #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_rd(i_rd), .i_addr1(i_addr1),
    .i_opSize(i_opSize), .i_tag(i_tag), .i_inv(i_inv), .i_ack(i_ack),
    .i_cdata(i_cdata), .i_ds_stall(i_ds_stall), .o_stall(o_stall),
    .o_req_v(o_req_v), .o_req_addr(o_req_addr), .o_v(o_v), .o_data(o_data),
    .o_tag(o_tag), .o_split_cnt(o_split_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Operand = the n bytes starting at addr (wrapping at 2^32), little-endian.
  function automatic logic [31:0] exp_data(input logic [31:0] addr, input int n);
    logic [31:0] r, a, w;
    r = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      w = mem_rd(a & 32'hFFFF_FFFC);
      r = r | (((w >> (8 * a[1:0])) & 32'hFF) << (8 * i));
    end
    return r;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (o_stall && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("idle_wait", {31'b0, o_stall}, 32'h0);
  endtask

  task automatic req_phase(input string nm, input logic [31:0] wa, input int dly);
    for (int k = 0; k < dly; k++) begin
      check_eq({nm, "_req_v"}, {31'b0, o_req_v}, 32'h1);
      check_eq({nm, "_stall"}, {31'b0, o_stall}, 32'h1);
      check_eq({nm, "_ov"}, {31'b0, o_v}, 32'h0);
      @(negedge clk);
    end
    check_eq({nm, "_req_v"}, {31'b0, o_req_v}, 32'h1);
    check_eq({nm, "_addr"}, o_req_addr, wa);
    i_ack   = 1'b1;
    i_cdata = mem_rd(wa);
    @(negedge clk);
    i_ack   = 1'b0;
    i_cdata = $urandom;
  endtask

  task automatic do_op(input logic [31:0] addr, input logic [1:0] sz, input logic rd,
                       input logic [TAG_W-1:0] tag, input int d1, input int d2, input int st);
    int n;
    logic [31:0] w1, w2, ed;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    w1 = addr & 32'hFFFF_FFFC;
    w2 = (addr + n - 1) & 32'hFFFF_FFFC;
    ed = rd ? exp_data(addr, n) : 32'h0;
    wait_idle();
    i_v = 1'b1; i_rd = rd; i_addr1 = addr; i_opSize = sz; i_tag = tag;
    @(negedge clk);
    i_v = 1'b0; i_addr1 = $urandom; i_tag = TAG_W'($urandom);
    if (rd) begin
      req_phase("req1", w1, d1);
      if (w1 != w2) begin
        req_phase("req2", w2, d2);
        if (cnt_m < 7) cnt_m++;
      end
    end
    check_eq("done_v", {31'b0, o_v}, 32'h1);
    check_eq("done_req_v", {31'b0, o_req_v}, 32'h0);
    check_eq("done_data", o_data, ed);
    check_eq("done_tag", {28'b0, o_tag}, {28'b0, tag});
    check_eq("split_cnt", {29'b0, o_split_cnt}, cnt_m);
    for (int k = 0; k < st; k++) begin
      i_ds_stall = 1'b1;
      i_ack      = $urandom_range(0, 1);
      @(negedge clk);
      check_eq("hold_v", {31'b0, o_v}, 32'h1);
      check_eq("hold_stall", {31'b0, o_stall}, 32'h1);
      check_eq("hold_data", o_data, ed);
      check_eq("hold_tag", {28'b0, o_tag}, {28'b0, tag});
    end
    i_ds_stall = 1'b0;
    i_ack      = 1'b0;
    @(negedge clk);
    check_eq("release_v", {31'b0, o_v}, 32'h0);
    check_eq("release_stall", {31'b0, o_stall}, 32'h0);
    check_eq("release_cnt", {29'b0, o_split_cnt}, cnt_m);
  endtask

  task automatic check_all_zero(input string nm);
    check_eq({nm, "_stall"}, {31'b0, o_stall}, 32'h0);
    check_eq({nm, "_req_v"}, {31'b0, o_req_v}, 32'h0);
    check_eq({nm, "_req_addr"}, o_req_addr, 32'h0);
    check_eq({nm, "_v"}, {31'b0, o_v}, 32'h0);
    check_eq({nm, "_data"}, o_data, 32'h0);
    check_eq({nm, "_tag"}, {28'b0, o_tag}, 32'h0);
    check_eq({nm, "_cnt"}, {29'b0, o_split_cnt}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1; i_v = 1'b0; i_rd = 1'b0; i_inv = 1'b0; i_ack = 1'b0; i_ds_stall = 1'b0;
    i_addr1 = 32'h0; i_cdata = 32'h0; i_opSize = 2'b00; i_tag = '0;
    mem[32'h0000_2000] = 32'hAABB_CCDD;
    mem[32'h1000_0000] = 32'h4433_2211;
    mem[32'h1000_0004] = 32'h8877_6655;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    do_op(32'h0000_2002, 2'b01, 1'b1, 4'h3, 0, 0, 0);
    check_eq("t1_data_const", exp_data(32'h0000_2002, 2), 32'h0000_AABB);
    do_op(32'h1000_0003, 2'b10, 1'b1, 4'h7, 0, 0, 0);
    check_eq("t2_data_const", exp_data(32'h1000_0003, 4), 32'h7766_5544);
    do_op(32'hFFFF_FFFE, 2'b10, 1'b1, 4'h9, 0, 1, 0);
    do_op(32'h0000_4000, 2'b10, 1'b1, 4'hC, 3, 0, 2);
    do_op(32'h0000_1234, 2'b11, 1'b0, 4'h5, 0, 0, 1);

    // Flush arriving with the second ack.
    wait_idle();
    i_v = 1'b1; i_rd = 1'b1; i_addr1 = 32'h1000_0003; i_opSize = 2'b10; i_tag = 4'hA;
    @(negedge clk);
    i_v = 1'b0;
    i_ack = 1'b1; i_cdata = mem_rd(32'h1000_0000);
    @(negedge clk);
    check_eq("fl_req2_addr", o_req_addr, 32'h1000_0004);
    i_ack = 1'b1; i_inv = 1'b1; i_cdata = mem_rd(32'h1000_0004);
    @(negedge clk);
    i_ack = 1'b0; i_inv = 1'b0;
    check_eq("fl_stall", {31'b0, o_stall}, 32'h0);
    check_eq("fl_req_v", {31'b0, o_req_v}, 32'h0);
    check_eq("fl_v", {31'b0, o_v}, 32'h0);
    check_eq("fl_cnt", {29'b0, o_split_cnt}, cnt_m);

    // Flush in IDLE blocks acceptance.
    i_v = 1'b1; i_inv = 1'b1; i_rd = 1'b1;
    @(negedge clk);
    i_v = 1'b0; i_inv = 1'b0;
    check_eq("idle_inv_stall", {31'b0, o_stall}, 32'h0);
    check_eq("idle_inv_req", {31'b0, o_req_v}, 32'h0);
    do_op(32'h0000_2002, 2'b00, 1'b1, 4'h1, 1, 0, 0);

    for (int t = 0; t < 70; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      do_op(ra, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0), TAG_W'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Asynchronous reset while a request is outstanding.
    wait_idle();
    i_v = 1'b1; i_rd = 1'b1; i_addr1 = 32'h0000_8000; i_opSize = 2'b10; i_tag = 4'hF;
    @(negedge clk);
    i_v = 1'b0;
    check_eq("pre_rst_req_v", {31'b0, o_req_v}, 32'h1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'h1000_0003, 2'b10, 1'b1, 4'h2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
